// File: rtl/register_bank_dbg.sv
// Register bank with two combinational read ports, optional write-to-read forwarding, and a
// ready/valid dump engine that streams every register out in address order.
module register_bank_dbg #(
  parameter int unsigned BANK_SIZE   = 32,
  parameter int unsigned ADDR_LENGTH = 5,
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned ZERO_REG    = 1,
  parameter int unsigned BYPASS      = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic [ADDR_LENGTH-1:0] i_regW,
  input  logic [DATA_LENGTH-1:0] i_Data,
  input  logic [ADDR_LENGTH-1:0] i_reg1,
  input  logic [ADDR_LENGTH-1:0] i_reg2,
  output logic [DATA_LENGTH-1:0] o_rg1D,
  output logic [DATA_LENGTH-1:0] o_rg2D,
  input  logic                   i_dump_start,
  input  logic                   i_dump_ready,
  output logic                   o_dump_valid,
  output logic [ADDR_LENGTH-1:0] o_dump_addr,
  output logic [DATA_LENGTH-1:0] o_dump_data,
  output logic                   o_dump_done,
  output logic                   o_busy
);

  localparam logic [ADDR_LENGTH:0]   BankSizeW = (ADDR_LENGTH + 1)'(BANK_SIZE);
  localparam logic [ADDR_LENGTH-1:0] LastIdx   = ADDR_LENGTH'(BANK_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} dump_state_e;

  logic [DATA_LENGTH-1:0] regs_q [BANK_SIZE];
  logic                   wr_ok;
  dump_state_e            state_q;
  logic [ADDR_LENGTH-1:0] idx_q;
  logic [ADDR_LENGTH-1:0] idx_next;
  logic [DATA_LENGTH-1:0] dump_data_q;
  logic                   dump_valid_q;
  logic                   dump_done_q;
  logic                   busy_q;

  // Address maps to a real, writable register (not out of range, not the hardwired zero).
  function automatic logic addr_live(input logic [ADDR_LENGTH-1:0] addr);
    return ({1'b0, addr} < BankSizeW) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  // Shared by both read ports and every dump load, so all see the same forwarding rules.
  function automatic logic [DATA_LENGTH-1:0] read_reg(input logic [ADDR_LENGTH-1:0] addr);
    logic [DATA_LENGTH-1:0] val;
    val = '0;
    if (addr_live(addr)) begin
      val = regs_q[addr];
      if ((BYPASS != 0) && wr_ok && (addr == i_regW)) val = i_Data;
    end
    return val;
  endfunction

  assign wr_ok    = i_enable && addr_live(i_regW);
  assign idx_next = idx_q + 1'b1;

  always_comb begin
    o_rg1D = read_reg(i_reg1);
    o_rg2D = read_reg(i_reg2);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      regs_q <= '{default: '0};
    end else if (wr_ok) begin
      regs_q[i_regW] <= i_Data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      dump_data_q  <= '0;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          dump_done_q <= 1'b0;
          if (i_dump_start) begin
            state_q      <= StSend;
            idx_q        <= '0;
            dump_data_q  <= read_reg('0);
            dump_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        StSend: begin
          // Without ready the word is held; later writes to that register do not disturb it.
          if (i_dump_ready) begin
            if (idx_q == LastIdx) begin
              state_q      <= StDone;
              dump_valid_q <= 1'b0;
              dump_done_q  <= 1'b1;
            end else begin
              idx_q       <= idx_next;
              dump_data_q <= read_reg(idx_next);
            end
          end
        end
        StDone: begin
          state_q     <= StIdle;
          idx_q       <= '0;
          dump_data_q <= '0;
          dump_done_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_dump_valid = dump_valid_q;
  assign o_dump_addr  = idx_q;
  assign o_dump_data  = dump_data_q;
  assign o_dump_done  = dump_done_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_register_bank_dbg.sv
// Directed bench for register_bank_dbg: reads/writes, forwarding (both settings), dump streaming,
// backpressure, ignored restart and reset abort.
module tb_register_bank_dbg;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [4:0]  reg_w;
  logic [31:0] data_in;
  logic [4:0]  reg1;
  logic [4:0]  reg2;
  logic [31:0] rg1_d, rg2_d, nb_rg1_d, nb_rg2_d;
  logic        dump_start, dump_ready;
  logic        dump_valid, dump_done, busy;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        nb_valid, nb_done, nb_busy;
  logic [4:0]  nb_addr;
  logic [31:0] nb_data;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [32];

  always #5 clk = ~clk;

  register_bank_dbg dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_regW(reg_w), .i_Data(data_in),
    .i_reg1(reg1), .i_reg2(reg2), .o_rg1D(rg1_d), .o_rg2D(rg2_d),
    .i_dump_start(dump_start), .i_dump_ready(dump_ready), .o_dump_valid(dump_valid),
    .o_dump_addr(dump_addr), .o_dump_data(dump_data), .o_dump_done(dump_done), .o_busy(busy)
  );

  register_bank_dbg #(.BYPASS(0)) dut_nb (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_regW(reg_w), .i_Data(data_in),
    .i_reg1(reg1), .i_reg2(reg2), .o_rg1D(nb_rg1_d), .o_rg2D(nb_rg2_d),
    .i_dump_start(dump_start), .i_dump_ready(dump_ready), .o_dump_valid(nb_valid),
    .o_dump_addr(nb_addr), .o_dump_data(nb_data), .o_dump_done(nb_done), .o_busy(nb_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    enable = 1'b1; reg_w = a; data_in = d;
    step();
    enable = 1'b0;
    if (a != 5'd0) model[a] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    reg1 = 5'd5; reg2 = 5'd31;
    #1;
    tests++;
    if ({dump_valid, dump_done, busy} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b want 000", {dump_valid, dump_done, busy});
    end
    tests++;
    if (dump_addr !== 5'd0 || dump_data !== 32'd0) begin
      fails++; $display("FAIL reset_dump_word: got %0d/%h want 0/0", dump_addr, dump_data);
    end
    tests++;
    if (rg1_d !== 32'd0 || rg2_d !== 32'd0) begin
      fails++; $display("FAIL reset_regs: got %h/%h want 0/0", rg1_d, rg2_d);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd1, 32'd5);
    do_write(5'd4, 32'd8);
    reg1 = 5'd1; reg2 = 5'd4;
    #1;
    tests++;
    if (rg1_d !== 32'd5 || rg2_d !== 32'd8) begin
      fails++; $display("FAIL write_read: got %0d/%0d want 5/8", rg1_d, rg2_d);
    end
    do_write(5'd0, 32'd7);
    reg1 = 5'd0;
    #1;
    tests++;
    if (rg1_d !== 32'd0 || nb_rg1_d !== 32'd0) begin
      fails++; $display("FAIL zero_reg: got %h/%h want 0/0", rg1_d, nb_rg1_d);
    end
  endtask

  task automatic test_bypass();
    do_write(5'd3, 32'h11);
    enable = 1'b1; reg_w = 5'd3; data_in = 32'hA5; reg1 = 5'd3; reg2 = 5'd4;
    #1;
    tests++;
    if (rg1_d !== 32'hA5) begin
      fails++; $display("FAIL bypass_on: got %h want a5", rg1_d);
    end
    tests++;
    if (nb_rg1_d !== 32'h11) begin
      fails++; $display("FAIL bypass_off: got %h want 11", nb_rg1_d);
    end
    tests++;
    if (rg2_d !== 32'd8) begin
      fails++; $display("FAIL bypass_other_port: got %h want 8", rg2_d);
    end
    step();
    enable = 1'b0;
    model[3] = 32'hA5;
    #1;
    tests++;
    if (rg1_d !== 32'hA5 || nb_rg1_d !== 32'hA5) begin
      fails++; $display("FAIL bypass_after_edge: got %h/%h want a5/a5", rg1_d, nb_rg1_d);
    end
    // Write to reg0 must not forward.
    enable = 1'b1; reg_w = 5'd0; data_in = 32'hFF; reg1 = 5'd0;
    #1;
    tests++;
    if (rg1_d !== 32'd0) begin
      fails++; $display("FAIL bypass_zero_reg: got %h want 0", rg1_d);
    end
    enable = 1'b0;
  endtask

  task automatic test_full_dump();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i * 3));
    dump_ready = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      tests++;
      if (dump_valid !== 1'b1 || busy !== 1'b1 || dump_addr !== 5'(k) || dump_data !== 32'(k * 3)) begin
        fails++;
        $display("FAIL full_dump word %0d: got v=%b b=%b a=%0d d=%0d want v=1 b=1 a=%0d d=%0d",
                 k, dump_valid, busy, dump_addr, dump_data, k, k * 3);
      end
      step();
    end
    tests++;
    if ({dump_valid, dump_done, busy} !== 3'b011) begin
      fails++; $display("FAIL full_dump_done: got v,d,b=%b want 011", {dump_valid, dump_done, busy});
    end
    step();
    tests++;
    if ({dump_valid, dump_done, busy} !== 3'b000) begin
      fails++; $display("FAIL full_dump_idle: got v,d,b=%b want 000", {dump_valid, dump_done, busy});
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    dump_ready = 1'b0;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      exp = model[k];
      // Rewrite the register being held; the latched word must not change.
      if (k == 5 || k == 17) begin
        enable = 1'b1; reg_w = 5'(k); data_in = 32'hDEAD_0000 + 32'(k);
      end
      step();
      enable = 1'b0;
      if (k == 5 || k == 17) model[k] = 32'hDEAD_0000 + 32'(k);
      tests++;
      if (dump_valid !== 1'b1 || dump_addr !== 5'(k) || dump_data !== exp) begin
        fails++;
        $display("FAIL backpressure_hold word %0d: got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                 k, dump_valid, dump_addr, dump_data, k, exp);
      end
      dump_ready = 1'b1;
      step();
      dump_ready = 1'b0;
    end
    tests++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
      fails++; $display("FAIL backpressure_done: got d=%b v=%b want d=1 v=0", dump_done, dump_valid);
    end
    step();
    tests++;
    if (model[5] !== 32'hDEAD_0005 || busy !== 1'b0) begin
      fails++; $display("FAIL backpressure_end: got busy=%b want 0", busy);
    end
    reg1 = 5'd17;
    #1;
    tests++;
    if (rg1_d !== 32'hDEAD_0011) begin
      fails++; $display("FAIL backpressure_rewrite: got %h want dead0011", rg1_d);
    end
  endtask

  task automatic test_restart_ignored();
    int exp_k = 0;
    int done_cnt = 0;
    int bad = 0;
    dump_ready = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (dump_valid) begin
        if (dump_addr !== 5'(exp_k) || dump_data !== model[exp_k]) begin
          bad++;
          $display("FAIL restart_word %0d: got a=%0d d=%h want a=%0d d=%h",
                   exp_k, dump_addr, dump_data, exp_k, model[exp_k]);
        end
        exp_k++;
      end
      if (dump_done) done_cnt++;
      dump_start = (dump_valid && dump_addr == 5'd10);
      step();
      dump_start = 1'b0;
    end
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (exp_k != 32 || done_cnt != 1) begin
      fails++; $display("FAIL restart_counts: got words=%0d done=%0d want 32/1", exp_k, done_cnt);
    end
  endtask

  task automatic test_reset_mid_dump();
    int guard = 0;
    int done_cnt = 0;
    dump_ready = 1'b1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    while (dump_addr != 5'd10 && guard < 40) begin
      step();
      guard++;
    end
    tests++;
    if (dump_addr !== 5'd10 || dump_valid !== 1'b1) begin
      fails++; $display("FAIL reset_mid_reach: got a=%0d v=%b want a=10 v=1", dump_addr, dump_valid);
    end
    dump_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    reg1 = 5'd1; reg2 = 5'd17;
    #1;
    tests++;
    if ({dump_valid, dump_done, busy} !== 3'b000 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got v,d,b=%b a=%0d d=%h want 000 0 0",
               {dump_valid, dump_done, busy}, dump_addr, dump_data);
    end
    tests++;
    if (rg1_d !== 32'd0 || rg2_d !== 32'd0) begin
      fails++; $display("FAIL reset_mid_regs: got %h/%h want 0/0", rg1_d, rg2_d);
    end
    for (int c = 0; c < 4; c++) begin
      if (dump_done) done_cnt++;
      step();
    end
    tests++;
    if (done_cnt != 0) begin
      fails++; $display("FAIL reset_mid_no_done: got %0d pulses want 0", done_cnt);
    end
    do_write(5'd2, 32'h77);
    dump_ready = 1'b0;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    tests++;
    if (dump_valid !== 1'b1 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
      fails++; $display("FAIL reset_mid_restart: got v=%b a=%0d d=%h want 1 0 0",
                        dump_valid, dump_addr, dump_data);
    end
    dump_ready = 1'b1;
    step(); step();
    tests++;
    if (dump_addr !== 5'd2 || dump_data !== 32'h77) begin
      fails++; $display("FAIL reset_mid_word2: got a=%0d d=%h want 2 77", dump_addr, dump_data);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; reg_w = '0; data_in = '0; reg1 = '0; reg2 = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_full_dump();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_dump();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
